// File: rtl/muldiv_seq_pkg.sv
// Shared core defines: ALU operation encoding, mul/div operation encoding, sizes.
package muldiv_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } control_alu_op_e;

  typedef enum logic [1:0] {
    MUL   = 2'd0,
    MULHU = 2'd1,
    DIVU  = 2'd2,
    REMU  = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // True for the two division-family operations.
  function automatic logic op_is_div(muldiv_op_e op);
    return (op == DIVU) || (op == REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Sequential 32-cycle shift-add multiplier / restoring divider borrowing a shared ALU.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [XLEN-1:0]       req_a_i,
  input  logic [XLEN-1:0]       req_b_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_result_o,
  input  logic                  flush_i,
  output logic                  alu_own_o,
  output logic [XLEN-1:0]       alu_a_o,
  output logic [XLEN-1:0]       alu_b_o,
  output control_alu_op_e       alu_op_o,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic                  alu_c_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op_q;
  muldiv_op_e       req_op_c;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  hi_q;   // product high half, or partial remainder
  logic [XLEN-1:0]  lo_q;   // product low half / multiplier, or quotient / dividend
  logic             accept_c;
  logic             div_zero_c;
  logic [XLEN-1:0]  rshift_c;
  logic             sub_ok_c;

  assign req_op_c   = muldiv_op_e'(req_op_i);
  assign accept_c   = req_valid_i && (state_q == ST_IDLE) && !flush_i;
  assign div_zero_c = op_is_div(req_op_c) && (req_b_i == '0);
  assign rshift_c   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  // A shifted-out remainder bit means r' >= 2^32 > divisor, so the subtract always fits.
  assign sub_ok_c   = !alu_c_i || hi_q[XLEN-1];

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state, handshake, ALU request and result selection.
  always_comb begin
    state_d       = state_q;
    req_ready_o   = (state_q == ST_IDLE);
    resp_valid_o  = 1'b0;
    resp_result_o = '0;
    alu_own_o     = 1'b0;
    alu_a_o       = '0;
    alu_b_o       = '0;
    alu_op_o      = ALU_ADD;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = div_zero_c ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        alu_own_o = 1'b1;
        alu_b_o   = b_q;
        if (op_is_div(op_q)) begin
          alu_a_o  = rshift_c;
          alu_op_o = ALU_SUB;
        end else begin
          alu_a_o  = hi_q;
        end
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_valid_o  = 1'b1;
        resp_result_o = (op_q == MULHU || op_q == REMU) ? hi_q : lo_q;
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Operand capture, iteration counter and shift/add or shift/subtract datapath.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      op_q  <= MUL;
      cnt_q <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            op_q  <= req_op_c;
            b_q   <= req_b_i;
            cnt_q <= '0;
            if (div_zero_c) begin
              hi_q <= req_a_i;
              lo_q <= '1;
            end else begin
              hi_q <= '0;
              lo_q <= req_a_i;
            end
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_is_div(op_q)) begin
            if (sub_ok_c) begin
              hi_q <= alu_result_i;
              lo_q <= {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_q <= rshift_c;
              lo_q <= {lo_q[XLEN-2:0], 1'b0};
            end
          end else if (lo_q[0]) begin
            hi_q <= {alu_c_i, alu_result_i[XLEN-1:1]};
            lo_q <= {alu_result_i[0], lo_q[XLEN-1:1]};
          end else begin
            hi_q <= {1'b0, hi_q[XLEN-1:1]};
            lo_q <= {hi_q[0], lo_q[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: parent-side ALU model plus arithmetic reference results.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      req_op_i;
  logic [31:0]     req_a_i;
  logic [31:0]     req_b_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [31:0]     resp_result_o;
  logic            flush_i;
  logic            alu_own_o;
  logic [31:0]     alu_a_o;
  logic [31:0]     alu_b_o;
  control_alu_op_e alu_op_o;
  logic [31:0]     alu_result_i;
  logic            alu_c_i;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_result_o(resp_result_o),
    .flush_i(flush_i),
    .alu_own_o(alu_own_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_c_i(alu_c_i)
  );

  always #5 clk_i = ~clk_i;

  // Shared ALU as the parent would provide it: carry out on ADD, borrow on SUB.
  always_comb begin
    alu_result_i = '0;
    alu_c_i      = 1'b0;
    case (alu_op_o)
      ALU_ADD: {alu_c_i, alu_result_i} = {1'b0, alu_a_o} + {1'b0, alu_b_o};
      ALU_SUB: begin
        alu_result_i = alu_a_o - alu_b_o;
        alu_c_i      = (alu_a_o < alu_b_o);
      end
      ALU_AND: alu_result_i = alu_a_o & alu_b_o;
      ALU_OR:  alu_result_i = alu_a_o | alu_b_o;
      default: ;
    endcase
  end

  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".ready"},  32'(req_ready_o),  32'd1);
    chk({tag, ".valid"},  32'(resp_valid_o), 32'd0);
    chk({tag, ".result"}, resp_result_o,     32'd0);
    chk({tag, ".own"},    32'(alu_own_o),    32'd0);
  endtask

  // Issue one operation, measure latency, hold the response for 'hold' cycles, then retire it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    logic        own_seen;
    exp      = ref_result(op, a, b);
    exp_lat  = (op[1] && b == 32'd0) ? 1 : 33;
    own_seen = 1'b0;
    check_idle({tag, ".pre"});
    req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b;
    step();
    req_valid_i = 1'b0; req_a_i = $urandom; req_b_i = $urandom;
    lat = 1;
    while (!resp_valid_o && lat < 60) begin
      own_seen |= alu_own_o;
      step();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".own_used"}, 32'(own_seen), (exp_lat == 1) ? 32'd0 : 32'd1);
    chk({tag, ".result"}, resp_result_o, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, ".hold_valid"},  32'(resp_valid_o), 32'd1);
      chk({tag, ".hold_result"}, resp_result_o, exp);
      chk({tag, ".hold_ready"},  32'(req_ready_o),  32'd0);
    end
    // Retire while a new request waits: it must not be taken on the retiring edge.
    resp_ready_i = 1'b1; req_valid_i = 1'b1;
    step();
    resp_ready_i = 1'b0; req_valid_i = 1'b0;
    check_idle({tag, ".post"});
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset_n_i = 1'b0; req_valid_i = 1'b0; req_op_i = 2'd0; req_a_i = '0; req_b_i = '0;
    resp_ready_i = 1'b0; flush_i = 1'b0;
    #2;
    check_idle("reset");
    step(); step();
    reset_n_i = 1'b1;
    step();
    check_idle("after_reset");

    run_op("mul_7x6",       2'(MUL),   32'd7, 32'd6, 0);
    run_op("mulhu_ff",      2'(MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mul_ff",        2'(MUL),   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("divu_100_7",    2'(DIVU),  32'd100, 32'd7, 0);
    run_op("remu_100_7",    2'(REMU),  32'd100, 32'd7, 0);
    run_op("divu_msb_1",    2'(DIVU),  32'h8000_0000, 32'd1, 0);
    run_op("divu_5_0",      2'(DIVU),  32'd5, 32'd0, 0);
    run_op("remu_5_0",      2'(REMU),  32'd5, 32'd0, 0);
    run_op("remu_big",      2'(REMU),  32'hFFFF_FFFF, 32'h8000_0001, 0);
    run_op("backpressure",  2'(MULHU), 32'h1234_5678, 32'h9ABC_DEF0, 10);

    // Flush at CALC cycle 12 abandons the operation.
    req_valid_i = 1'b1; req_op_i = 2'(MUL); req_a_i = 32'd11; req_b_i = 32'd13;
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("flush.in_calc", 32'(alu_own_o), 32'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check_idle("flush.idle");
    for (int i = 0; i < 40; i++) step();
    chk("flush.no_resp", 32'(resp_valid_o), 32'd0);

    // Flush beats a simultaneous accept.
    req_valid_i = 1'b1; flush_i = 1'b1;
    step();
    req_valid_i = 1'b0; flush_i = 1'b0;
    check_idle("flush_vs_accept");

    // Flush drops a pending response.
    req_valid_i = 1'b1; req_op_i = 2'(DIVU); req_a_i = 32'd9; req_b_i = 32'd0;
    step();
    req_valid_i = 1'b0;
    chk("flush_done.valid_before", 32'(resp_valid_o), 32'd1);
    flush_i = 1'b1; resp_ready_i = 1'b0;
    step();
    flush_i = 1'b0;
    check_idle("flush_done");

    // Reset pulse mid-CALC discards the operation.
    req_valid_i = 1'b1; req_op_i = 2'(DIVU); req_a_i = 32'd1000; req_b_i = 32'd3;
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("rst_mid.in_calc", 32'(alu_own_o), 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    check_idle("rst_mid.during");
    step();
    reset_n_i = 1'b1;
    step();
    check_idle("rst_mid.after");
    for (int i = 0; i < 40; i++) step();
    chk("rst_mid.no_resp", 32'(resp_valid_o), 32'd0);
    run_op("mul_3x3", 2'(MUL), 32'd3, 32'd3, 0);

    // Random operations against the arithmetic reference.
    for (int k = 0; k < 30; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", k), rop, ra, rb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
